instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
- Responder (memory end) of the syn/ack/last instruction-streaming handshake driven by the fetch stage.
- Holds a 2^DEPTH-word instruction store and a program-length register, and streams words in address order while the fetch side holds syn.
- Pulses ack with each word and flags the final word with last.
- Has a write port so the bench or a boot loader can load the program before or during streaming.

Parameters:
- IWIDTH, 32, instruction width in bits.
- DEPTH, 6, address width; store holds 2^DEPTH words.
- WAIT_CYCLES, 1, wait states from request to ack, 0..15.
- INIT_FILE, "", hex image path; used only with the optional feature.

Ports:
- r_clk  input  1  clock; all state updates on its rising edge.
- r_rst  input  1  reset, asynchronous, active-high.
- r_i_syn  input  1  fetch request; held high while words are wanted.
- r_o_instr  output  IWIDTH  instruction word; valid only while r_o_ack=1.
- r_o_ack  output  1  one-cycle pulse marking a delivered word.
- r_o_last  output  1  high with ack on the final program word.
- r_o_done  output  1  high while the program is fully streamed.
- r_i_wr_en  input  1  store write strobe.
- r_i_wr_addr  input  DEPTH  store write address.
- r_i_wr_data  input  IWIDTH  store write data.
- r_i_len_we  input  1  length register write strobe.
- r_i_len  input  DEPTH  index of the last program word.

Behaviour:
- Reset (asynchronous, immediate, legal mid-stream):
  - r_o_instr=0, r_o_ack=0, r_o_last=0, r_o_done=0.
  - rd_ptr=0, wait counter=0, last_idx=2^DEPTH-1, state IDLE.
  - Store contents are not cleared.
- All outputs are registered.
- States: IDLE, WAIT, ACK, DONE.
- IDLE:
  - syn=1 and WAIT_CYCLES>0 -> load counter with WAIT_CYCLES, go WAIT.
  - syn=1 and WAIT_CYCLES=0 -> go ACK.
- WAIT:
  - Counter decrements each cycle; at 1 -> ACK.
  - syn=0 -> abort to IDLE; rd_ptr unchanged; no ack is issued.
- ACK (exactly one cycle):
  - r_o_ack=1, r_o_instr=mem[rd_ptr], r_o_last=(rd_ptr>=last_idx).
  - Latency from syn rise to ack high is WAIT_CYCLES+1 cycles.
  - On exit, ack and last return to 0 and r_o_instr holds its value.
- ACK exit:
  - Last word -> DONE; rd_ptr holds.
  - Otherwise rd_ptr+1, then:
    - syn=1 -> WAIT, or ACK again when WAIT_CYCLES=0, giving back-to-back acks.
    - syn=0 -> IDLE.
- DONE:
  - r_o_done=1, no acks.
  - Stays while syn=1.
  - syn=0 -> rd_ptr=0, r_o_done=0, go IDLE, ready to restream.
- Boundaries:
  - rd_ptr cannot pass 2^DEPTH-1 because last_idx<=2^DEPTH-1, so no wrap.
  - Length register write takes effect next cycle. If the new last_idx<=rd_ptr, the next ack carries last=1.
  - Write to the address being read in the same cycle -> ack carries the old word (read-before-write). The new word is visible from the next read.
  - Writes are accepted in every state and are not blocked by streaming.
  - Simultaneous wr_en and len_we -> both performed.

Optional Feature:
- Macro: INSTR_MEM_INIT_EN.
- Defined:
  - Store is initialised at elaboration from INIT_FILE via readmemh.
  - last_idx reset value is 2^DEPTH-1; r_i_len_we still overrides it.
- Undefined:
  - INIT_FILE is ignored; store content is X until written through the write port.

Test Plan:
- Load 0x20010005, 0x20020003, 0x00221820, 0xAC030000 at addrs 0..3, len=3, WAIT_CYCLES=1, hold syn=1 -> four acks every 2 cycles with the words in order; last=1 only on 0xAC030000; done=1 from the next cycle.
- WAIT_CYCLES=0, same program, syn held -> acks on 4 consecutive cycles, last on the 4th.
- Drop syn during WAIT before the 2nd word, raise it 3 cycles later -> no ack while low; next ack carries 0x20020003.
- Assert r_rst in the cycle after the 2nd ack -> all outputs 0 immediately; with syn high after release, the first ack carries 0x20010005.
- After 2 acks (rd_ptr=2), write len=1 -> the next ack carries 0x00221820 with last=1, then done=1.
- In DONE, drop syn 1 cycle, then raise it -> done clears and streaming restarts at 0x20010005.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Memory-side responder for the syn/ack/last instruction stream. It holds a
// 2^DEPTH-word store and a program-length register, and streams words in
// address order while the fetch side holds syn.
// Latency: syn rise to ack is WAIT_CYCLES+1 cycles; with WAIT_CYCLES=0 and syn
// held, acks arrive back to back. Backpressure: dropping syn aborts a pending
// wait without consuming a word; a word is never delivered while syn is low.
// Ports: r_clk/r_rst (async active-high); r_i_syn request in; r_o_instr,
// r_o_ack, r_o_last, r_o_done registered outputs; r_i_wr_* store write port;
// r_i_len_we/r_i_len set the index of the last program word.
module instr_mem_responder #(
  parameter int    IWIDTH      = 32,
  parameter int    DEPTH       = 6,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              r_i_syn,
  output logic [IWIDTH-1:0] r_o_instr,
  output logic              r_o_ack,
  output logic              r_o_last,
  output logic              r_o_done,
  input  logic              r_i_wr_en,
  input  logic [DEPTH-1:0]  r_i_wr_addr,
  input  logic [IWIDTH-1:0] r_i_wr_data,
  input  logic              r_i_len_we,
  input  logic [DEPTH-1:0]  r_i_len
);

  localparam int              WORDS    = 1 << DEPTH;
  localparam logic [3:0]      WAIT_LD  = 4'(WAIT_CYCLES);
  localparam logic [DEPTH-1:0] LAST_MAX = {DEPTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DEPTH-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]    last_idx_q, last_idx_d;
  logic [IWIDTH-1:0]   instr_q, instr_d;
  logic                ack_q, ack_d;
  logic                last_q, last_d;
  logic                done_q, done_d;

  // Instruction store; deliberately not reset so a loaded program survives.
  logic [IWIDTH-1:0]   mem_q [WORDS];

  logic unused_init_file;
  assign unused_init_file = (INIT_FILE != "");

  // Write port is independent of streaming. A read of the same address in
  // the same cycle sees the old word because the store updates at the edge.
  always_ff @(posedge r_clk) begin
    if (r_i_wr_en) begin
      mem_q[r_i_wr_addr] <= r_i_wr_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    last_idx_d = r_i_len_we ? r_i_len : last_idx_q;
    instr_d    = instr_q;
    ack_d      = 1'b0;
    last_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (r_i_syn) begin
          if (WAIT_CYCLES > 0) begin
            cnt_d   = WAIT_LD;
            state_d = S_WAIT;
          end else begin
            state_d = S_ACK;
          end
        end
      end
      S_WAIT: begin
        if (!r_i_syn) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        // last_q is the flag that went out with this word, so the decision
        // to stop matches exactly what the fetch side was told.
        if (last_q) begin
          state_d = S_DONE;
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (r_i_syn) begin
            if (WAIT_CYCLES > 0) begin
              cnt_d   = WAIT_LD;
              state_d = S_WAIT;
            end else begin
              state_d = S_ACK;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DONE: begin
        if (!r_i_syn) begin
          rd_ptr_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered against the next state, so ack rises in the
    // same cycle the FSM sits in ACK. Reading at rd_ptr_d keeps back-to-back
    // acks on consecutive addresses.
    if (state_d == S_ACK) begin
      ack_d   = 1'b1;
      instr_d = mem_q[rd_ptr_d];
      last_d  = (rd_ptr_d >= last_idx_q);
    end
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      last_idx_q <= LAST_MAX;
      instr_q    <= '0;
      ack_q      <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      last_idx_q <= last_idx_d;
      instr_q    <= instr_d;
      ack_q      <= ack_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  assign r_o_instr = instr_q;
  assign r_o_ack   = ack_q;
  assign r_o_last  = last_q;
  assign r_o_done  = done_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
module tb_instr_mem_responder;
  localparam int IW = 32;
  localparam int DP = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          syn_a, syn_b;
  logic          wr_en;
  logic [DP-1:0] wr_addr;
  logic [IW-1:0] wr_data;
  logic          len_we;
  logic [DP-1:0] len;

  logic [IW-1:0] a_instr, b_instr;
  logic          a_ack, a_last, a_done;
  logic          b_ack, b_last, b_done;

  // Instance A runs with one wait state, instance B with none.
  instr_mem_responder #(.IWIDTH(IW), .DEPTH(DP), .WAIT_CYCLES(1), .INIT_FILE("")) u_a (
    .r_clk(clk), .r_rst(rst), .r_i_syn(syn_a),
    .r_o_instr(a_instr), .r_o_ack(a_ack), .r_o_last(a_last), .r_o_done(a_done),
    .r_i_wr_en(wr_en), .r_i_wr_addr(wr_addr), .r_i_wr_data(wr_data),
    .r_i_len_we(len_we), .r_i_len(len)
  );

  instr_mem_responder #(.IWIDTH(IW), .DEPTH(DP), .WAIT_CYCLES(0), .INIT_FILE("")) u_b (
    .r_clk(clk), .r_rst(rst), .r_i_syn(syn_b),
    .r_o_instr(b_instr), .r_o_ack(b_ack), .r_o_last(b_last), .r_o_done(b_done),
    .r_i_wr_en(wr_en), .r_i_wr_addr(wr_addr), .r_i_wr_data(wr_data),
    .r_i_len_we(len_we), .r_i_len(len)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference: store contents and the index of the last program word.
  logic [IW-1:0] ref_mem [0:63];
  int            ref_len;

  logic [IW-1:0] prog [0:3];

  task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic observe(input bit sel, output logic ack, output logic last,
                         output logic done, output logic [IW-1:0] instr);
    ack   = sel ? b_ack   : a_ack;
    last  = sel ? b_last  : a_last;
    done  = sel ? b_done  : a_done;
    instr = sel ? b_instr : a_instr;
  endtask

  task automatic set_syn(input bit sel, input logic v);
    if (sel) syn_b = v;
    else     syn_a = v;
  endtask

  task automatic wr(input int addr, input logic [IW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = DP'(addr);
    wr_data = data;
    tick;
    wr_en = 1'b0;
    ref_mem[addr] = data;
  endtask

  task automatic set_len(input int v);
    len_we = 1'b1;
    len    = DP'(v);
    tick;
    len_we = 1'b0;
    ref_len = v;
  endtask

  // Raise syn and expect words first..ref_len, one every (W+1) cycles, with
  // last only on the final one, then done.
  task automatic stream(input bit sel, input int first, input string tag);
    int w;
    logic ack, last, done;
    logic [IW-1:0] ins;
    w = sel ? 0 : 1;
    set_syn(sel, 1'b1);
    for (int j = first; j < 64; j++) begin
      for (int c = 1; c <= w + 1; c++) begin
        tick;
        observe(sel, ack, last, done, ins);
        chk({tag, " ack"}, IW'(ack), IW'(c == w + 1));
        if (c == w + 1) begin
          chk({tag, " instr"}, ins, ref_mem[j]);
          chk({tag, " last"}, IW'(last), IW'(j >= ref_len));
        end
      end
      if (j >= ref_len) break;
    end
    tick;
    observe(sel, ack, last, done, ins);
    chk({tag, " done"}, IW'(done), 1);
    chk({tag, " no ack in done"}, IW'(ack), 0);
  endtask

  task automatic drop_syn(input bit sel, input string tag);
    logic ack, last, done;
    logic [IW-1:0] ins;
    set_syn(sel, 1'b0);
    tick;
    observe(sel, ack, last, done, ins);
    chk({tag, " done clear"}, IW'(done), 0);
    chk({tag, " ack idle"}, IW'(ack), 0);
  endtask

  initial begin
    logic ack, last, done;
    logic [IW-1:0] ins;
    int n;
    bit sel;

    prog[0] = 32'h20010005;
    prog[1] = 32'h20020003;
    prog[2] = 32'h00221820;
    prog[3] = 32'hAC030000;

    rst = 1'b1; syn_a = 1'b0; syn_b = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; len_we = 1'b0; len = '0;
    ref_len = 63;
    #2;
    chk("reset a_instr", a_instr, 0);
    chk("reset a_ack", IW'(a_ack), 0);
    chk("reset a_last", IW'(a_last), 0);
    chk("reset a_done", IW'(a_done), 0);
    chk("reset b_ack", IW'(b_ack), 0);
    chk("reset b_done", IW'(b_done), 0);
    tick;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) wr(i, prog[i]);
    set_len(3);

    // One wait state: ack every two cycles, then done held while syn stays.
    stream(0, 0, "w1 stream");
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("done held", IW'(a_done), 1);
      chk("done no ack", IW'(a_ack), 0);
    end
    drop_syn(0, "done exit");
    stream(0, 0, "restream");
    drop_syn(0, "restream exit");

    // No wait states: back-to-back acks.
    stream(1, 0, "w0 stream");
    drop_syn(1, "w0 exit");

    // Abort during WAIT before the 2nd word.
    syn_a = 1'b1;
    tick; tick;
    chk("abort w0 ack", IW'(a_ack), 1);
    chk("abort w0 instr", a_instr, prog[0]);
    tick;
    chk("abort wait ack", IW'(a_ack), 0);
    syn_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort syn low ack", IW'(a_ack), 0);
    end
    stream(0, 1, "abort resume");
    drop_syn(0, "abort exit");

    // Shorten the program below rd_ptr while streaming.
    syn_a = 1'b1;
    tick; tick;
    chk("len w0 instr", a_instr, prog[0]);
    tick; tick;
    chk("len w1 ack", IW'(a_ack), 1);
    chk("len w1 instr", a_instr, prog[1]);
    len_we = 1'b1; len = DP'(1);
    tick;
    len_we = 1'b0; ref_len = 1;
    chk("len wait ack", IW'(a_ack), 0);
    tick;
    chk("len w2 ack", IW'(a_ack), 1);
    chk("len w2 instr", a_instr, prog[2]);
    chk("len w2 last", IW'(a_last), 1);
    tick;
    chk("len done", IW'(a_done), 1);
    drop_syn(0, "len exit");
    set_len(3);

    // Read-before-write on the address being delivered.
    syn_b = 1'b1;
    wr_en = 1'b1; wr_addr = '0; wr_data = 32'hDEADBEEF;
    tick;
    wr_en = 1'b0;
    observe(1, ack, last, done, ins);
    chk("rbw ack", IW'(ack), 1);
    chk("rbw old word", ins, prog[0]);
    ref_mem[0] = 32'hDEADBEEF;
    stream(1, 1, "rbw rest");
    drop_syn(1, "rbw exit");
    stream(1, 0, "rbw new word");
    drop_syn(1, "rbw new exit");
    wr(0, prog[0]);

    // Asynchronous reset in the cycle after the 2nd ack.
    syn_a = 1'b1;
    tick; tick; tick; tick;
    chk("rst pre ack", IW'(a_ack), 1);
    chk("rst pre instr", a_instr, prog[1]);
    rst = 1'b1;
    #1;
    chk("rst async instr", a_instr, 0);
    chk("rst async ack", IW'(a_ack), 0);
    chk("rst async last", IW'(a_last), 0);
    chk("rst async done", IW'(a_done), 0);
    tick;
    rst = 1'b0;
    ref_len = 63;
    tick;
    chk("rst release wait", IW'(a_ack), 0);
    tick;
    chk("rst first ack", IW'(a_ack), 1);
    chk("rst first instr", a_instr, prog[0]);
    chk("rst default len", IW'(a_last), 0);
    syn_a = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    set_len(3);

    // Randomized programs on either instance.
    for (int it = 0; it < 8; it++) begin
      n = (it == 0) ? 0 : int'($urandom_range(0, 9));
      for (int i = 0; i <= n; i++) wr(i, $urandom);
      set_len(n);
      sel = bit'($urandom_range(0, 1));
      stream(sel, 0, "rand");
      drop_syn(sel, "rand exit");
    end

    // Full-depth program: last word at the top address, no wrap.
    for (int i = 0; i < 64; i++) wr(i, $urandom);
    set_len(63);
    stream(1, 0, "full depth");
    drop_syn(1, "full depth exit");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
